efpga_sync_fifo: RTL

EFPGA_SYNC_FIFO -- requirements
Module: efpga_sync_fifo

---
 rtl/efpga_fifo_pkg.sv | 13 +
 rtl/efpga_fifo_mem.sv | 33 +++
 rtl/efpga_sync_fifo.sv | 89 ++++++++
 3 files changed

// File: rtl/efpga_fifo_pkg.sv
// efpga_fifo_pkg: shared defaults and status bundle for the eFPGA synchronous FIFO
package efpga_fifo_pkg;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_FIFO_DEPTH = 16;
  typedef struct packed {
    logic empty;
    logic almost_empty;
    logic full;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;
endpackage

// File: rtl/efpga_fifo_mem.sv
// efpga_fifo_mem: 1W1R register-array storage, no reset on contents
// Ports: clk_i/rstn_i clock and async active-low reset (read register only);
//        wen_i/waddr_i/wdata_i write port; ren_i/raddr_i/rdata_o read port.
// Macro EFPGA_FIFO_FWFT_EN: combinational read instead of registered read.
module efpga_fifo_mem #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int A_WIDTH = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               wen_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               ren_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]   rdata_o
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk_i)
    if (wen_i) r_mem[waddr_i] <= wdata_i;
`ifdef EFPGA_FIFO_FWFT_EN
  logic w_unused;
  assign w_unused = ren_i ^ rstn_i;
  assign rdata_o  = r_mem[raddr_i];
`else
  logic [WIDTH-1:0] r_rdata;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) r_rdata <= '0;
    else if (ren_i) r_rdata <= r_mem[raddr_i];
  assign rdata_o = r_rdata;
`endif
endmodule

// File: rtl/efpga_sync_fifo.sv
// efpga_sync_fifo: single-clock FIFO with level, threshold flags and sticky errors
// Ports: clk_i, rstn_i (async active-low), flush_i, push_i/wdata_i, pop_i/rdata_o,
//        ae_thresh_i/af_thresh_i, level_o, empty/almost_empty/full/almost_full_o,
//        overflow_o/underflow_o (sticky), clr_err_i.
// Macro EFPGA_FIFO_FWFT_EN: first-word-fall-through read (default: 1-cycle read latency).
module efpga_sync_fifo
  import efpga_fifo_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int A_WIDTH    = $clog2(FIFO_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  input  logic [A_WIDTH:0] ae_thresh_i,
  input  logic [A_WIDTH:0] af_thresh_i,
  output logic [A_WIDTH:0] level_o,
  output logic             empty_o,
  output logic             almost_empty_o,
  output logic             full_o,
  output logic             almost_full_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             clr_err_i
);
  localparam logic [A_WIDTH:0] L_FULL = (A_WIDTH+1)'(FIFO_DEPTH);
  logic [A_WIDTH-1:0] r_wptr, r_rptr;
  logic [A_WIDTH:0]   r_level;
  logic               r_ovf, r_unf;
  logic               w_push_ok, w_pop_ok, w_wen, w_ren;
  logic [WIDTH-1:0]   w_mem_rdata;
  fifo_status_t       w_status;
  always_comb begin
    w_status.empty        = r_level == '0;
    w_status.almost_empty = r_level <= ae_thresh_i;
    w_status.full         = r_level == L_FULL;
    w_status.almost_full  = r_level >= af_thresh_i;
    w_status.overflow     = r_ovf;
    w_status.underflow    = r_unf;
  end
  assign w_push_ok = push_i & ~w_status.full;
  assign w_pop_ok  = pop_i & ~w_status.empty;
  // flush overrides both sides, so nothing is written or read that cycle
  assign w_wen = w_push_ok & ~flush_i;
  assign w_ren = w_pop_ok & ~flush_i;
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_wptr  <= flush_i ? '0 : r_wptr + A_WIDTH'(w_wen);
      r_rptr  <= flush_i ? '0 : r_rptr + A_WIDTH'(w_ren);
      r_level <= flush_i ? '0 : r_level + (A_WIDTH+1)'(w_wen) - (A_WIDTH+1)'(w_ren);
      // set has priority over clear
      r_ovf   <= (push_i & w_status.full & ~flush_i) | (r_ovf & ~clr_err_i);
      r_unf   <= (pop_i & w_status.empty & ~flush_i) | (r_unf & ~clr_err_i);
    end
  efpga_fifo_mem #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH), .A_WIDTH(A_WIDTH)) u_mem (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .wen_i   (w_wen),
    .waddr_i (r_wptr),
    .wdata_i (wdata_i),
    .ren_i   (w_ren),
    .raddr_i (r_rptr),
    .rdata_o (w_mem_rdata)
  );
`ifdef EFPGA_FIFO_FWFT_EN
  // stale storage is hidden while empty so reset/flush present zero
  assign rdata_o = w_status.empty ? '0 : w_mem_rdata;
`else
  assign rdata_o = w_mem_rdata;
`endif
  assign level_o        = r_level;
  assign empty_o        = w_status.empty;
  assign almost_empty_o = w_status.almost_empty;
  assign full_o         = w_status.full;
  assign almost_full_o  = w_status.almost_full;
  assign overflow_o     = w_status.overflow;
  assign underflow_o    = w_status.underflow;
endmodule
